// File: rtl/conv_dims_seq.sv
// ---------------------------------------------------------------------------
// conv_dims_seq
//   Sequential convolution output-size calculator. For each axis it computes
//     out = (IN + 2*PAD - (DIL*(K-1)+1)) / STRIDE + 1
//   One restoring divider is shared by the height and width axes, so the
//   two divisions run back to back. The latency is fixed because a division
//   always runs, even for an axis whose descriptor is invalid.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   descriptor handshake (accepted only in IDLE)
//   IN_HEIGHT, IN_WIDTH   input feature-map size
//   KERNEL_H, KERNEL_W    kernel size per axis (0 gives an effective kernel of 0)
//   STRIDE_H, STRIDE_W    stride per axis (0 is reported as an error)
//   PAD_H, PAD_W          padding per side, per axis
//   DILATION              dilation for both axes (0 is treated as 1)
//   out_valid / out_ready result handshake
//   OUT_HEIGHT, OUT_WIDTH results (saturate to 2^W-1, 0 on a flagged axis)
//   err_stride            a stride was zero
//   err_kernel            the dilated kernel exceeds the padded input
//   err_ovf               a result saturated
// ---------------------------------------------------------------------------
module conv_dims_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] IN_HEIGHT,
  input  logic [W-1:0] IN_WIDTH,
  input  logic [W-1:0] KERNEL_H,
  input  logic [W-1:0] KERNEL_W,
  input  logic [W-1:0] STRIDE_H,
  input  logic [W-1:0] STRIDE_W,
  input  logic [W-1:0] PAD_H,
  input  logic [W-1:0] PAD_W,
  input  logic [W-1:0] DILATION,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] OUT_HEIGHT,
  output logic [W-1:0] OUT_WIDTH,
  output logic         err_stride,
  output logic         err_kernel,
  output logic         err_ovf
);

  localparam int NW = W + 2;          // dividend and quotient width
  localparam int KW = 2 * W + 1;      // effective kernel width
  localparam int QW = W + 3;          // quotient + 1
  localparam int RW = W + 1;          // partial remainder width
  localparam int CW = $clog2(NW);     // iteration counter width

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_DIV_H,
    S_DIV_W,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_inH, r_inW, r_kH, r_kW, r_sH, r_sW, r_pH, r_pW, r_dil;
  logic [NW-1:0] r_div;
  logic [NW-1:0] r_numW;
  logic [RW-1:0] r_rem;
  logic [NW-2:0] r_quo;
  logic [CW-1:0] r_cnt;
  logic          r_badKH, r_badKW;
  logic [W-1:0]  r_resH;
  logic          r_ovfH;

  // Returns {kernel_too_large, dividend}. The padded size is compared against
  // the effective kernel in full width; when it is not too large the
  // difference fits in NW bits.
  function automatic logic [NW:0] axisPrep(
    input logic [W-1:0] inDim,
    input logic [W-1:0] k,
    input logic [W-1:0] pad,
    input logic [W-1:0] dil
  );
    logic [W-1:0]  dilEff;
    logic [KW-1:0] keff;
    logic [KW-1:0] padded;
    logic          bad;
    logic [NW-1:0] diff;
    dilEff = (dil == '0) ? W'(1) : dil;
    if (k == '0) begin
      keff = '0;
    end else begin
      keff = ({{(W+1){1'b0}}, dilEff} * {{(W+1){1'b0}}, k - W'(1)}) + KW'(1);
    end
    padded = KW'(inDim) + KW'({pad, 1'b0});
    bad    = (padded < keff);
    diff   = NW'(padded - keff);
    return {bad, diff};
  endfunction

  // Returns {saturated, result}. A flagged axis always reports 0.
  function automatic logic [W:0] axisFinish(
    input logic [NW-1:0] q,
    input logic          bad
  );
    logic [QW-1:0] q1;
    logic [W:0]    res;
    q1 = QW'(q) + QW'(1);
    if (bad) begin
      res = '0;
    end else if (q1[QW-1:W] != '0) begin
      res = {1'b1, {W{1'b1}}};
    end else begin
      res = {1'b0, q1[W-1:0]};
    end
    return res;
  endfunction

  logic [NW:0]   w_prepH, w_prepW;
  logic [W-1:0]  w_divisor;
  logic          w_axisBad;
  logic [NW-1:0] w_remShift;
  logic          w_ge;
  logic [RW-1:0] w_remNext;
  logic [NW-1:0] w_quoNext;
  logic [W:0]    w_fin;
  logic          w_lastIter;

  // One restoring-division step for whichever axis is being divided, plus
  // the per-axis preparation and the final result of the current axis.
  always_comb begin
    w_prepH    = axisPrep(r_inH, r_kH, r_pH, r_dil);
    w_prepW    = axisPrep(r_inW, r_kW, r_pW, r_dil);
    w_divisor  = (r_state == S_DIV_W) ? r_sW : r_sH;
    w_axisBad  = (r_state == S_DIV_W) ? ((r_sW == '0) || r_badKW)
                                      : ((r_sH == '0) || r_badKH);
    w_remShift = {r_rem, r_div[NW-1]};
    w_ge       = (w_remShift >= {2'b00, w_divisor});
    if (w_ge) begin
      w_remNext = RW'(w_remShift - {2'b00, w_divisor});
    end else begin
      w_remNext = w_remShift[RW-1:0];
    end
    w_quoNext  = {r_quo, w_ge};
    w_fin      = axisFinish(w_quoNext, w_axisBad);
    w_lastIter = (r_cnt == CW'(NW - 1));
  end

  // Control FSM, shared divider datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      OUT_HEIGHT <= '0;
      OUT_WIDTH  <= '0;
      err_stride <= 1'b0;
      err_kernel <= 1'b0;
      err_ovf    <= 1'b0;
      r_inH      <= '0;
      r_inW      <= '0;
      r_kH       <= '0;
      r_kW       <= '0;
      r_sH       <= '0;
      r_sW       <= '0;
      r_pH       <= '0;
      r_pW       <= '0;
      r_dil      <= '0;
      r_div      <= '0;
      r_numW     <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
      r_badKH    <= 1'b0;
      r_badKW    <= 1'b0;
      r_resH     <= '0;
      r_ovfH     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_inH    <= IN_HEIGHT;
            r_inW    <= IN_WIDTH;
            r_kH     <= KERNEL_H;
            r_kW     <= KERNEL_W;
            r_sH     <= STRIDE_H;
            r_sW     <= STRIDE_W;
            r_pH     <= PAD_H;
            r_pW     <= PAD_W;
            r_dil    <= DILATION;
            in_ready <= 1'b0;
            r_state  <= S_PREP;
          end
        end
        S_PREP: begin
          r_div   <= w_prepH[NW-1:0];
          r_badKH <= w_prepH[NW];
          r_numW  <= w_prepW[NW-1:0];
          r_badKW <= w_prepW[NW];
          r_rem   <= '0;
          r_quo   <= '0;
          r_cnt   <= '0;
          r_state <= S_DIV_H;
        end
        S_DIV_H: begin
          if (w_lastIter) begin
            // Park the height result and reload the divider for width.
            r_resH  <= w_fin[W-1:0];
            r_ovfH  <= w_fin[W];
            r_div   <= r_numW;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_state <= S_DIV_W;
          end else begin
            r_rem   <= w_remNext;
            r_quo   <= w_quoNext[NW-2:0];
            r_div   <= {r_div[NW-2:0], 1'b0};
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        S_DIV_W: begin
          if (w_lastIter) begin
            OUT_HEIGHT <= r_resH;
            OUT_WIDTH  <= w_fin[W-1:0];
            err_ovf    <= r_ovfH | w_fin[W];
            err_stride <= (r_sH == '0) || (r_sW == '0);
            err_kernel <= r_badKH | r_badKW;
            out_valid  <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_rem   <= w_remNext;
            r_quo   <= w_quoNext[NW-2:0];
            r_div   <= {r_div[NW-2:0], 1'b0};
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_dims_seq.sv
// ---------------------------------------------------------------------------
// tb_conv_dims_seq
//   Self-checking bench for conv_dims_seq (W=16). A monitor records every
//   accepted descriptor together with its expected results, computed with
//   plain integer arithmetic. A compare process checks the handshake and
//   result outputs on every falling edge, including the exact result latency
//   and the hold of the last results between transactions.
// ---------------------------------------------------------------------------
module tb_conv_dims_seq;

  localparam int     W    = 16;
  localparam int     LAT  = 2 * W + 5;
  localparam longint MAXV = (64'd1 << W) - 1;

  typedef struct packed {
    logic [W-1:0] inH, inW, kH, kW, sH, sW, pH, pW, dil;
  } desc_t;

  typedef struct {
    longint h;
    longint w;
    bit     es;
    bit     ek;
    bit     eo;
    int     acc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] OUT_HEIGHT;
  logic [W-1:0] OUT_WIDTH;
  logic         err_stride;
  logic         err_kernel;
  logic         err_ovf;
  desc_t        drv;

  exp_t expQ[$];
  exp_t lastRes;
  exp_t zeroRes;
  int   compared   = 0;
  int   mismatched = 0;
  int   edgeCount  = 0;

  conv_dims_seq #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .IN_HEIGHT  (drv.inH),
    .IN_WIDTH   (drv.inW),
    .KERNEL_H   (drv.kH),
    .KERNEL_W   (drv.kW),
    .STRIDE_H   (drv.sH),
    .STRIDE_W   (drv.sW),
    .PAD_H      (drv.pH),
    .PAD_W      (drv.pW),
    .DILATION   (drv.dil),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .OUT_HEIGHT (OUT_HEIGHT),
    .OUT_WIDTH  (OUT_WIDTH),
    .err_stride (err_stride),
    .err_kernel (err_kernel),
    .err_ovf    (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string name, input longint actual, input longint required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0d required %0d (t=%0t)", name, actual, required, $time);
    end
  endtask

  // Output size of one axis straight from the arithmetic definition.
  function automatic void axisModel(input longint inD, input longint k, input longint s,
                                    input longint p, input longint dil,
                                    output longint res, output bit badS,
                                    output bit badK, output bit ovf);
    longint d, keff, num;
    d    = (dil == 0) ? 1 : dil;
    keff = (k == 0) ? 0 : d * (k - 1) + 1;
    num  = inD + 2 * p - keff;
    badS = (s == 0);
    badK = (num < 0);
    ovf  = 1'b0;
    res  = 0;
    if (!badS && !badK) begin
      res = num / s + 1;
      if (res > MAXV) begin
        res = MAXV;
        ovf = 1'b1;
      end
    end
  endfunction

  function automatic exp_t modelDesc(input desc_t d);
    exp_t   e;
    longint rh, rw;
    bit     sh, kh, oh, sw, kw, ow;
    axisModel(d.inH, d.kH, d.sH, d.pH, d.dil, rh, sh, kh, oh);
    axisModel(d.inW, d.kW, d.sW, d.pW, d.dil, rw, sw, kw, ow);
    e.h   = rh;
    e.w   = rw;
    e.es  = sh | sw;
    e.ek  = kh | kw;
    e.eo  = oh | ow;
    e.acc = 0;
    return e;
  endfunction

  function automatic desc_t mk(input int inH, input int inW, input int kH, input int kW,
                               input int sH, input int sW, input int pH, input int pW,
                               input int dil);
    desc_t d;
    d.inH = W'(inH); d.inW = W'(inW); d.kH = W'(kH); d.kW = W'(kW);
    d.sH  = W'(sH);  d.sW  = W'(sW);  d.pH = W'(pH); d.pW = W'(pW);
    d.dil = W'(dil);
    return d;
  endfunction

  function automatic desc_t randDesc();
    desc_t d;
    if ($urandom_range(0, 3) == 0) begin
      d.inH = W'($urandom);            d.inW = W'($urandom);
      d.pH  = W'($urandom);            d.pW  = W'($urandom_range(0, 40));
      d.kH  = W'($urandom_range(0, 9)); d.kW = W'($urandom);
      d.sH  = W'($urandom_range(0, 3)); d.sW = W'($urandom_range(1, 65535));
      d.dil = W'($urandom_range(0, 4));
    end else begin
      d.inH = W'($urandom_range(0, 100)); d.inW = W'($urandom_range(0, 100));
      d.kH  = W'($urandom_range(0, 9));   d.kW  = W'($urandom_range(0, 9));
      d.sH  = W'($urandom_range(0, 4));   d.sW  = W'($urandom_range(0, 4));
      d.pH  = W'($urandom_range(0, 5));   d.pW  = W'($urandom_range(0, 5));
      d.dil = W'($urandom_range(0, 3));
    end
    return d;
  endfunction

  // Monitor: every accepted descriptor is queued with its expected results.
  always @(posedge clk) begin
    exp_t e;
    edgeCount++;
    if (rst_n && in_valid && in_ready) begin
      e     = modelDesc(drv);
      e.acc = edgeCount;
      expQ.push_back(e);
    end
  end

  // Compare process: the oldest queued result is due exactly LAT edges after
  // its accept edge and stays up until the consumer takes it; otherwise the
  // outputs hold the last delivered result.
  always @(negedge clk) begin
    bit   expValid;
    exp_t cur;
    if (!rst_n) begin
      expQ.delete();
      lastRes = zeroRes;
      checkOutput("reset in_ready", in_ready, 1);
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset OUT_HEIGHT", OUT_HEIGHT, 0);
      checkOutput("reset OUT_WIDTH", OUT_WIDTH, 0);
      checkOutput("reset err_stride", err_stride, 0);
      checkOutput("reset err_kernel", err_kernel, 0);
      checkOutput("reset err_ovf", err_ovf, 0);
    end else begin
      expValid = (expQ.size() > 0) && ((edgeCount - expQ[0].acc) >= LAT);
      checkOutput("out_valid", out_valid, expValid);
      checkOutput("in_ready", in_ready, expQ.size() == 0);
      cur = expValid ? expQ[0] : lastRes;
      checkOutput("OUT_HEIGHT", OUT_HEIGHT, cur.h);
      checkOutput("OUT_WIDTH", OUT_WIDTH, cur.w);
      checkOutput("err_stride", err_stride, cur.es);
      checkOutput("err_kernel", err_kernel, cur.ek);
      checkOutput("err_ovf", err_ovf, cur.eo);
      if (expValid && out_ready) begin
        lastRes = expQ[0];
        void'(expQ.pop_front());
      end
    end
  end

  // Offers a descriptor until it is accepted (bounded), then drops in_valid.
  task automatic applyStimulus(input desc_t d);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    drv      = d;
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      n++;
      if (in_ready && rst_n) begin
        @(posedge clk);
        acc = 1'b1;
      end
    end
    #1 in_valid = 1'b0;
    checkOutput("descriptor accepted", acc, 1);
  endtask

  // Waits (bounded) for the result handshake, optionally toggling out_ready.
  task automatic waitResult(input bit randomReady);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (out_valid && out_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        if (randomReady) out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    out_ready = 1'b1;
    checkOutput("result handshake", done, 1);
  endtask

  // Pins the reference model to hand-computed results.
  task automatic pinModel();
    exp_t e;
    e = modelDesc(mk(32, 32, 3, 3, 1, 1, 1, 1, 1));
    checkOutput("model 3x3 same h", e.h, 32);
    checkOutput("model 3x3 same w", e.w, 32);
    e = modelDesc(mk(28, 28, 5, 5, 2, 2, 0, 0, 1));
    checkOutput("model 5x5 s2 h", e.h, 12);
    e = modelDesc(mk(28, 28, 5, 5, 2, 2, 0, 0, 2));
    checkOutput("model dil2 keff9 h", e.h, 10);
    e = modelDesc(mk(10, 10, 3, 3, 1, 1, 0, 0, 2));
    checkOutput("model dil2 keff5 w", e.w, 6);
    e = modelDesc(mk(28, 28, 5, 5, 2, 2, 0, 0, 0));
    checkOutput("model dil0 h", e.h, 12);
    e = modelDesc(mk(32, 32, 3, 3, 2, 0, 0, 0, 1));
    checkOutput("model stride0 h", e.h, 15);
    checkOutput("model stride0 w", e.w, 0);
    checkOutput("model stride0 err", e.es, 1);
    e = modelDesc(mk(4, 4, 7, 3, 1, 1, 0, 0, 1));
    checkOutput("model bigkernel h", e.h, 0);
    checkOutput("model bigkernel w", e.w, 2);
    checkOutput("model bigkernel err", e.ek, 1);
    e = modelDesc(mk(65535, 2, 1, 1, 1, 1, 65535, 0, 1));
    checkOutput("model sat h", e.h, 65535);
    checkOutput("model sat ovf", e.eo, 1);
    checkOutput("model sat w", e.w, 2);
  endtask

  initial begin
    int    n;
    desc_t c1;
    zeroRes   = '{h: 0, w: 0, es: 1'b0, ek: 1'b0, eo: 1'b0, acc: 0};
    lastRes   = zeroRes;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drv       = '0;
    c1        = mk(32, 32, 3, 3, 1, 1, 1, 1, 1);

    pinModel();

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed descriptors");
    applyStimulus(c1);                                   waitResult(1'b0);
    applyStimulus(mk(28, 28, 5, 5, 2, 2, 0, 0, 1));      waitResult(1'b0);
    applyStimulus(mk(28, 28, 5, 5, 2, 2, 0, 0, 2));      waitResult(1'b0);
    applyStimulus(mk(10, 10, 3, 3, 1, 1, 0, 0, 2));      waitResult(1'b0);
    applyStimulus(mk(28, 28, 5, 5, 2, 2, 0, 0, 0));      waitResult(1'b0);
    applyStimulus(mk(32, 32, 3, 3, 2, 0, 0, 0, 1));      waitResult(1'b0);
    applyStimulus(mk(4, 4, 7, 3, 1, 1, 0, 0, 1));        waitResult(1'b0);
    applyStimulus(mk(65535, 2, 1, 1, 1, 1, 65535, 0, 1)); waitResult(1'b0);

    $display("[TB] back-pressure in DONE with ignored in_valid pulses");
    out_ready = 1'b0;
    applyStimulus(mk(20, 17, 3, 2, 1, 2, 1, 0, 1));
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached DONE", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      drv      = randDesc();
      in_valid = (i % 2 == 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitResult(1'b0);
    applyStimulus(mk(28, 28, 5, 5, 2, 2, 0, 0, 1));      waitResult(1'b0);
    applyStimulus(mk(4, 4, 7, 3, 1, 1, 0, 0, 1));        waitResult(1'b0);

    $display("[TB] reset during height division");
    applyStimulus(c1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset in_ready", in_ready, 1);
    checkOutput("async reset out_valid", out_valid, 0);
    checkOutput("async reset OUT_WIDTH", OUT_WIDTH, 0);
    checkOutput("async reset err_kernel", err_kernel, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(c1);                                   waitResult(1'b0);

    $display("[TB] randomized descriptors");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(randDesc());
      waitResult(1'b1);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, actual running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
